if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM chip-enable and address.
- Captures the ROM's combinational instruction word into a registered IF/ID slot, with a valid/ready handshake toward decode.
- Handles control-hazard redirects (jump/flush), pipeline hold, and misaligned-target faults.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction placed in the IF/ID slot when it is empty or flushed (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (`RstEnable = 1'b0`).
- jump_flag_i  in  1  redirect request from execute; highest priority.
- jump_addr_i  in  32  redirect target.
- hold_i  in  1  pipeline hold from ctrl; freezes PC advance.
- rom_ce_o  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`).
- rom_addr_o  out  32  ROM byte address; always equals the PC.
- rom_inst_i  in  32  ROM read data; combinational and valid in the same cycle.
- id_valid_o  out  1  IF/ID slot holds a live instruction.
- id_inst_o  out  32  instruction in the slot.
- id_inst_addr_o  out  32  PC of the instruction in the slot.
- id_ready_i  in  1  decode accepts the slot this cycle.
- fault_o  out  1  sticky misaligned-fetch fault.
- fault_addr_o  out  32  offending target address.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_ADDR, state=BOOT.
  - id_valid_o=0, id_inst_o=NOP_INST, id_inst_addr_o=0.
  - fault_o=0, fault_addr_o=0, rom_ce_o=0.
- States: BOOT, RUN, FAULT. The state register is sampled only on clk and rst.
- BOOT:
  - rom_ce_o=0, slot empty.
  - Unconditionally moves to RUN on the next edge, giving one ce-low cycle after reset release.
- RUN:
  - rom_ce_o=1, rom_addr_o=pc.
  - advance = !hold_i && (!id_valid_o || id_ready_i).
  - On advance: id_inst_o<=rom_inst_i, id_inst_addr_o<=pc, id_valid_o<=1, pc<=pc+4.
  - !advance with hold_i=1, id_valid_o=1, id_ready_i=1: the slot is consumed, so id_valid_o<=0. PC and data are unchanged.
  - !advance otherwise: slot and PC hold all values.
  - Latency: an instruction at address A presented at cycle N (pc=A, advance) appears on id_* at N+1.
- Jump (jump_flag_i=1 in RUN, overrides hold_i and the handshake):
  - id_valid_o<=0, id_inst_o<=NOP_INST, pc<=jump_addr_i.
  - The target is read from the ROM at N+1 and is visible on id_* at N+2, so each jump costs one bubble.
- Misaligned jump (jump_addr_i[1:0]!=0):
  - Go to FAULT: fault_o<=1, fault_addr_o<=jump_addr_i, slot flushed, pc unchanged.
- FAULT:
  - rom_ce_o=0, id_valid_o=0.
  - All inputs are ignored; the state is sticky until rst.
- PC arithmetic:
  - 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
  - pc[1:0] is always 00.
- Simultaneous events: priority is rst > jump_flag_i > hold_i > handshake.
- Reset mid-stall or mid-fault returns to BOOT with all reset values.
- id_* data is stable while id_valid_o=1 and id_ready_i=0.

Decomposition:
- Shared define file (existing, extended): RstEnable, ChipEnable/ChipDisable, ZeroWord, InstAddrBus/InstBus, a new `NopInst`, and the fetch state encodings FETCH_BOOT/FETCH_RUN/FETCH_FAULT.
- One natural sub-module: if_id_slot, holding the registered valid/inst/addr slot with its load/clear/hold logic.
- PC and FSM stay in if_fetch.

Test Plan:
- Reset release:
  - rst low for 3 cycles, then high: rom_ce_o=0 during reset and in the first cycle after release.
  - Then rom_ce_o=1 with rom_addr_o=0, and id_valid_o=1 with id_inst_addr_o=0 one cycle later.
- Sequential fetch:
  - ROM model mem[i]=32'h1000_0000+i, id_ready_i=1.
  - id_* yields (0,0x10000000), (4,0x10000001), (8,0x10000002) on consecutive cycles.
- Backpressure:
  - id_ready_i=0 for 3 cycles while the slot holds addr 8: id_* is frozen and rom_addr_o stays at 12.
  - On release, 12 follows the next cycle with no skip or duplicate.
- Hold:
  - hold_i=1, id_ready_i=1 for 2 cycles: the slot drains (id_valid_o=0) and pc stays constant.
  - After hold drops, fetch resumes at the held pc.
- Jump:
  - jump_flag_i=1, jump_addr_i=0x40 while hold_i=1 and id_ready_i=0: next cycle id_valid_o=0 and rom_addr_o=0x40.
  - The cycle after: id_inst_addr_o=0x40.
- Fault and wrap:
  - jump_addr_i=0x42: fault_o=1, fault_addr_o=0x42, rom_ce_o=0, and the state persists for 10 cycles until rst.
  - Separately, jump to 0xFFFF_FFFC: the next fetch address is 0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
//   Shared definitions for the instruction-fetch stage. These include reset
//   and chip-enable levels, bus constants, the default NOP word, the fetch
//   state encoding, and a small alignment helper.
// ---------------------------------------------------------------------------
package if_fetch_pkg;

  // Reset is active-low.
  localparam logic RST_ENABLE   = 1'b0;

  // ROM chip-enable levels.
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  // Instruction address and instruction word constants.
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [31:0] INST_STEP        = 32'h0000_0004;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  // Fetch controller states.
  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  // An instruction address is legal only when it is word aligned.
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/if_id_slot.sv
// ---------------------------------------------------------------------------
// if_id_slot
//   Registered IF/ID pipeline slot. It holds one fetched instruction and its
//   PC, together with a valid bit.
//   Control priority: flush > load > drain > hold.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   flush_i  in   empty the slot and replace the word with NOP
//   load_i   in   capture inst_i/addr_i and mark the slot valid
//   drain_i  in   mark the slot empty but keep its data
//   inst_i   in   instruction word to capture
//   addr_i   in   PC of that instruction
//   valid_o  out  slot holds a live instruction
//   inst_o   out  instruction in the slot
//   addr_o   out  PC of the instruction in the slot
// ---------------------------------------------------------------------------
module if_id_slot
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] addr_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] addr_o
);

  logic        valid_q, valid_d;
  logic [31:0] inst_q,  inst_d;
  logic [31:0] addr_q,  addr_d;

  // Next-state logic for the slot. The default is to hold every field,
  // which keeps the data stable while decode applies backpressure.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    if (flush_i) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else if (load_i) begin
      valid_d = 1'b1;
      inst_d  = inst_i;
      addr_d  = addr_i;
    end else if (drain_i) begin
      // Decode took the instruction, but nothing new is being fetched.
      valid_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      addr_q  <= ZERO_WORD;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch stage placed directly in front of a combinational
//   instruction ROM. It owns the PC and the ROM chip enable. Each fetched
//   word is registered into an IF/ID slot that uses a valid/ready handshake
//   toward decode. The stage also handles redirects from execute, pipeline
//   hold, and sticky faults on misaligned redirect targets.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-low reset
//   jump_flag_i    in   redirect request (highest priority after reset)
//   jump_addr_i    in   redirect target
//   hold_i         in   pipeline hold; freezes PC advance
//   rom_ce_o       out  ROM chip enable
//   rom_addr_o     out  ROM byte address (always the PC)
//   rom_inst_i     in   ROM read data, valid in the same cycle
//   id_valid_o     out  IF/ID slot holds a live instruction
//   id_inst_o      out  instruction in the slot
//   id_inst_addr_o out  PC of the instruction in the slot
//   id_ready_i     in   decode accepts the slot this cycle
//   fault_o        out  sticky misaligned-fetch fault
//   fault_addr_o   out  offending redirect target
// ---------------------------------------------------------------------------
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_inst_addr_o,
  input  logic        id_ready_i,
  output logic        fault_o,
  output logic [31:0] fault_addr_o
);

  // The low PC bits are forced to zero so the PC stays word aligned even if
  // RESET_ADDR is given an unaligned value.
  localparam logic [31:0] RESET_PC = {RESET_ADDR[31:2], 2'b00};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_addr_q, fault_addr_d;

  logic         slot_valid;
  logic         slot_load;
  logic         slot_flush;
  logic         slot_drain;
  logic         advance;
  logic         rom_ce;

  // A new word may enter the slot when the pipeline is not held and the
  // slot is either empty or being consumed this cycle.
  assign advance = !hold_i && (!slot_valid || id_ready_i);

  // Next-state and control logic for the fetch FSM.
  // BOOT gives exactly one chip-disabled cycle after reset is released.
  // RUN fetches, with a redirect taking priority over hold and the
  // handshake. FAULT is terminal until reset.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    slot_load    = 1'b0;
    slot_flush   = 1'b0;
    slot_drain   = 1'b0;
    rom_ce       = CHIP_DISABLE;

    case (state_q)
      FETCH_BOOT: begin
        state_d = FETCH_RUN;
      end

      FETCH_RUN: begin
        rom_ce = CHIP_ENABLE;
        if (jump_flag_i) begin
          slot_flush = 1'b1;
          if (addr_misaligned(jump_addr_i)) begin
            // Leave the PC where it is and record the bad target.
            state_d      = FETCH_FAULT;
            fault_d      = 1'b1;
            fault_addr_d = jump_addr_i;
          end else begin
            pc_d = jump_addr_i;
          end
        end else if (advance) begin
          slot_load = 1'b1;
          pc_d      = pc_q + INST_STEP;
        end else if (hold_i && slot_valid && id_ready_i) begin
          // Under hold, decode may still take the current slot. In that
          // case the slot empties, but the PC is not advanced.
          slot_drain = 1'b1;
        end
      end

      FETCH_FAULT: begin
        // Every input is ignored. The slot was flushed on entry and is
        // never loaded again.
        rom_ce = CHIP_DISABLE;
      end

      default: begin
        state_d = FETCH_BOOT;
      end
    endcase
  end

  // State, PC and fault registers.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q      <= FETCH_BOOT;
      pc_q         <= RESET_PC;
      fault_q      <= 1'b0;
      fault_addr_q <= ZERO_WORD;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  if_id_slot #(
    .NOP_INST (NOP_INST)
  ) u_slot (
    .clk     (clk),
    .rst     (rst),
    .flush_i (slot_flush),
    .load_i  (slot_load),
    .drain_i (slot_drain),
    .inst_i  (rom_inst_i),
    .addr_i  (pc_q),
    .valid_o (slot_valid),
    .inst_o  (id_inst_o),
    .addr_o  (id_inst_addr_o)
  );

  assign rom_ce_o     = rom_ce;
  assign rom_addr_o   = pc_q;
  assign id_valid_o   = slot_valid;
  assign fault_o      = fault_q;
  assign fault_addr_o = fault_addr_q;

endmodule
